volt_calc: RTL and testbench
============================

Name: volt_calc

Overview:
- Upstream arithmetic stage of the digital voltmeter.
- Generates the ADC conversion clock and samples the 8-bit ADC code.
- At startup, self-calibrates the zero-volt code (median) by averaging samples taken with 0 V applied.
- In run mode, converts each sample to a signed millivolt magnitude (−5000..+5000 mV) for the BCD/segment display stage downstream.

Parameters:
- AD_DIV, 2: ad_clk half-period in sys_clk cycles (≥1).
- CAL_LOG2, 10: log2 of the calibration sample count (1024 samples).
- FS_MV, 5000: full-scale magnitude in mV.
- FRAC, 13: fractional bits of the fixed-point scale factors.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  synchronous active-low reset, sampled on sys_clk rising edge.
- ad_data  in  8  ADC code. Changes on the ad_clk falling edge.
- ad_clk  out  1  ADC conversion clock. Registered output.
- volt_mv  out  13  magnitude in mV, 0..5000.
- volt_sign  out  1  1 = negative.
- volt_valid  out  1  one-cycle strobe; volt_mv/volt_sign are updated on this cycle.
- median  out  8  calibrated zero code, after clamping.
- cal_done  out  1  high while in RUN.

Behaviour:
- Reset (sync, active-low):
  - Outputs: ad_clk=0, volt_mv=0, volt_sign=0, volt_valid=0, median=0, cal_done=0.
  - Internal: div_cnt=0, accumulator=0, sample count=0, state=CAL_ACC.
  - Reset asserted mid-calibration, mid-divide or in RUN discards all progress; calibration restarts from zero.
- Clock divider:
  - div_cnt counts 0..AD_DIV-1; ad_clk toggles on the cycle where div_cnt==AD_DIV-1.
  - samp_stb is a one-cycle pulse on the cycle ad_clk goes 0→1. On that cycle, ad_data is registered into samp.
  - samp_stb fires every 2*AD_DIV cycles in all states.
- State CAL_ACC:
  - Each samp_stb adds samp to a (CAL_LOG2+8)-bit accumulator and increments the count.
  - On the cycle the 2^CAL_LOG2-th sample is accumulated, go to DIV_P.
  - That cycle also sets median = accumulator>>CAL_LOG2 (truncated), clamped to 1..254 (0→1, 255→254).
- State DIV_P:
  - Restoring divider, one quotient bit per cycle, 26 cycles.
  - Computes scale_p = floor((FS_MV<<FRAC)/(255−median)). Dividend 40960000 fits 26 bits.
  - Then go to DIV_N.
- State DIV_N:
  - Same divider, 26 cycles.
  - Computes scale_n = floor((FS_MV<<FRAC)/median).
  - Then go to RUN; cal_done=1 from the first RUN cycle.
- samp_stb during DIV_P/DIV_N is ignored; volt_valid stays 0.
- State RUN, 2-stage pipeline:
  - Cycle s (samp_stb): samp captured.
  - Stage 1, cycle s+1: diff = |samp−median| (8 bit); sign = (samp<median); factor select.
    - samp > median: scale_p.
    - samp < median: scale_n.
    - samp == median: diff=0, sign=0.
  - Stage 2, cycle s+2: product = diff×factor (34 bit); volt_mv = product>>FRAC (truncate); volt_sign = sign; volt_valid=1 for this single cycle.
- Arithmetic guarantee: volt_mv ≤ 5000 for every input. The median clamp guarantees no division by zero.
- Outputs hold their last value between strobes.

Optional Feature:
- Macro: RECAL_EN.
- Defined: adds input port recal (1 bit), placed after ad_data.
  - A recal=1 sampled in RUN returns the block to CAL_ACC on the next cycle.
  - The same transition clears the accumulator and count, and sets cal_done=0.
  - volt_mv/volt_sign/median hold their values until overwritten.
  - An in-flight pipeline strobe is suppressed.
  - recal is ignored outside RUN.
- Undefined: no recal port; calibration runs only after reset.

Test Plan:
- Calibration result: reset release, ad_data=125 constant → median=125, scale_p=315076, scale_n=327680.
  - cal_done rises exactly 52 cycles after the cycle the 1024th sample is accumulated.
  - volt_valid stays 0 throughout calibration.
- Conversion values, median 125:
  - ad_data 255 → 4999, sign 0.
  - ad_data 0 → 5000, sign 1.
  - ad_data 126 → 38, sign 0.
  - ad_data 124 → 40, sign 1.
  - ad_data 125 → 0, sign 0.
  - volt_valid is exactly 2 cycles after samp_stb.
- Ramp 0..255 after calibration, one step per ad_clk period:
  - volt_mv is monotonic non-increasing up to code 125, then non-decreasing.
  - Never exceeds 5000; one volt_valid per ad_clk period.
- Clamp: calibrate with ad_data=255 → median=254, scale_p=40960000, scale_n=161259; ad_data 255 → 5000, sign 0.
  - Calibrate with ad_data=0 → median=1.
- Reset: assert sys_rst_n=0 for 1 cycle during DIV_P → all outputs return to reset values; recalibration from 0 with a new constant 100 → median=100.
- RECAL_EN build: in RUN, change ad_data to 130, pulse recal 1 cycle → cal_done falls next cycle; after recalibration median=130.

Source files
------------

// File: rtl/volt_calc.sv
// Voltmeter arithmetic stage: ADC clock generation, zero-code self-calibration and
// signed millivolt conversion. Optional `RECAL_EN adds a recal input for runtime recalibration.
module volt_calc #(
    parameter int AD_DIV   = 2,
    parameter int CAL_LOG2 = 10,
    parameter int FS_MV    = 5000,
    parameter int FRAC     = 13
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  ad_data,
`ifdef RECAL_EN
    input  logic        recal,
`endif
    output logic        ad_clk,
    output logic [12:0] volt_mv,
    output logic        volt_sign,
    output logic        volt_valid,
    output logic [7:0]  median,
    output logic        cal_done,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        CAL_ACC = 2'd0,
        DIV_P   = 2'd1,
        DIV_N   = 2'd2,
        RUN     = 2'd3
    } state_t;

    localparam int DC_W              = (AD_DIV > 1) ? $clog2(AD_DIV) : 1;
    localparam int ACC_W             = CAL_LOG2 + 8;
    localparam logic [25:0] DIVIDEND = 26'(FS_MV << FRAC);

    state_t              state_q;
    logic [DC_W-1:0]     div_cnt_q;
    logic                ad_clk_q;
    logic                samp_stb_q;
    logic [7:0]          samp_q;
    logic [ACC_W-1:0]    acc_q;
    logic [CAL_LOG2-1:0] cnt_q;
    logic [7:0]          median_q;
    logic [25:0]         quo_q;
    logic [7:0]          rem_q;
    logic [4:0]          bit_q;
    logic [25:0]         scale_p_q;
    logic [25:0]         scale_n_q;
    logic [7:0]          diff_q;
    logic                sign_q;
    logic [25:0]         factor_q;
    logic                stb1_q;
    logic [12:0]         volt_mv_q;
    logic                volt_sign_q;
    logic                volt_valid_q;
    logic                cal_done_q;

    logic                div_wrap;
    logic [ACC_W-1:0]    acc_sum;
    logic [7:0]          avg;
    logic [7:0]          med_clamped;
    logic [7:0]          divisor;
    logic [8:0]          rem_sh;
    logic                rem_ge;
    logic [7:0]          rem_d;
    logic [25:0]         quo_d;
    logic [7:0]          diff_d;
    logic                sign_d;
    logic [25:0]         factor_d;
    logic [33:0]         product;
    logic                recal_hit;

`ifdef RECAL_EN
    assign recal_hit = recal && (state_q == RUN);
`else
    assign recal_hit = 1'b0;
`endif

    assign div_wrap = (div_cnt_q == DC_W'(AD_DIV - 1));

    // Calibration average, clamped so neither scale divisor can reach zero.
    always_comb begin
        acc_sum     = acc_q + ACC_W'(samp_q);
        avg         = 8'(acc_sum >> CAL_LOG2);
        med_clamped = avg;
        if (avg == 8'd0) begin
            med_clamped = 8'd1;
        end else if (avg == 8'd255) begin
            med_clamped = 8'd254;
        end
    end

    // One restoring-division step; quo_q shifts the dividend out and the quotient in.
    always_comb begin
        divisor = (state_q == DIV_P) ? (8'd255 - median_q) : median_q;
        rem_sh  = {rem_q, quo_q[25]};
        rem_ge  = (rem_sh >= {1'b0, divisor});
        rem_d   = rem_ge ? 8'(rem_sh - {1'b0, divisor}) : rem_sh[7:0];
        quo_d   = {quo_q[24:0], rem_ge};
    end

    always_comb begin
        diff_d   = 8'd0;
        sign_d   = 1'b0;
        factor_d = 26'd0;
        if (samp_q > median_q) begin
            diff_d   = samp_q - median_q;
            factor_d = scale_p_q;
        end else if (samp_q < median_q) begin
            diff_d   = median_q - samp_q;
            sign_d   = 1'b1;
            factor_d = scale_n_q;
        end
    end

    assign product = 34'(diff_q) * 34'(factor_q);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= CAL_ACC;
            div_cnt_q    <= '0;
            ad_clk_q     <= 1'b0;
            samp_stb_q   <= 1'b0;
            samp_q       <= 8'd0;
            acc_q        <= '0;
            cnt_q        <= '0;
            median_q     <= 8'd0;
            quo_q        <= 26'd0;
            rem_q        <= 8'd0;
            bit_q        <= 5'd0;
            scale_p_q    <= 26'd0;
            scale_n_q    <= 26'd0;
            diff_q       <= 8'd0;
            sign_q       <= 1'b0;
            factor_q     <= 26'd0;
            stb1_q       <= 1'b0;
            volt_mv_q    <= 13'd0;
            volt_sign_q  <= 1'b0;
            volt_valid_q <= 1'b0;
            cal_done_q   <= 1'b0;
        end else begin
            if (div_wrap) begin
                div_cnt_q <= '0;
                ad_clk_q  <= ~ad_clk_q;
            end else begin
                div_cnt_q <= div_cnt_q + DC_W'(1);
            end
            // The sample strobe coincides with the first cycle ad_clk reads high.
            samp_stb_q <= div_wrap && !ad_clk_q;
            if (div_wrap && !ad_clk_q) begin
                samp_q <= ad_data;
            end
            stb1_q       <= 1'b0;
            volt_valid_q <= 1'b0;

            case (state_q)
                CAL_ACC: begin
                    if (samp_stb_q) begin
                        acc_q <= acc_sum;
                        cnt_q <= cnt_q + CAL_LOG2'(1);
                        if (&cnt_q) begin
                            median_q <= med_clamped;
                            quo_q    <= DIVIDEND;
                            rem_q    <= 8'd0;
                            bit_q    <= 5'd0;
                            state_q  <= DIV_P;
                        end
                    end
                end
                DIV_P: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    bit_q <= bit_q + 5'd1;
                    if (bit_q == 5'd25) begin
                        scale_p_q <= quo_d;
                        quo_q     <= DIVIDEND;
                        rem_q     <= 8'd0;
                        bit_q     <= 5'd0;
                        state_q   <= DIV_N;
                    end
                end
                DIV_N: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    bit_q <= bit_q + 5'd1;
                    if (bit_q == 5'd25) begin
                        scale_n_q  <= quo_d;
                        bit_q      <= 5'd0;
                        cal_done_q <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (recal_hit) begin
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        cal_done_q <= 1'b0;
                        state_q    <= CAL_ACC;
                    end else begin
                        if (samp_stb_q) begin
                            diff_q   <= diff_d;
                            sign_q   <= sign_d;
                            factor_q <= factor_d;
                            stb1_q   <= 1'b1;
                        end
                        if (stb1_q) begin
                            volt_mv_q    <= 13'(product >> FRAC);
                            volt_sign_q  <= sign_q;
                            volt_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= CAL_ACC;
            endcase
        end
    end

    assign ad_clk     = ad_clk_q;
    assign volt_mv    = volt_mv_q;
    assign volt_sign  = volt_sign_q;
    assign volt_valid = volt_valid_q;
    assign median     = median_q;
    assign cal_done   = cal_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_volt_calc.sv
// Directed bench for volt_calc: calibration, conversion values, ramp, clamp and reset cases.
// Build with +define+RECAL_EN to add the runtime recalibration step.
module tb_volt_calc;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [7:0]  ad_data;
`ifdef RECAL_EN
    logic        recal;
`endif
    logic        ad_clk;
    logic [12:0] volt_mv;
    logic        volt_sign;
    logic        volt_valid;
    logic [7:0]  median;
    logic        cal_done;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int valid_cnt = 0;

    volt_calc dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .ad_data    (ad_data),
`ifdef RECAL_EN
        .recal      (recal),
`endif
        .ad_clk     (ad_clk),
        .volt_mv    (volt_mv),
        .volt_sign  (volt_sign),
        .volt_valid (volt_valid),
        .median     (median),
        .cal_done   (cal_done),
        .dbg_state  (dbg_state)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (volt_valid === 1'b1) valid_cnt++;
    end

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ad_clk"}, 32'(ad_clk), 0);
        check({tag, "_volt_mv"}, 32'(volt_mv), 0);
        check({tag, "_volt_sign"}, 32'(volt_sign), 0);
        check({tag, "_volt_valid"}, 32'(volt_valid), 0);
        check({tag, "_median"}, 32'(median), 0);
        check({tag, "_cal_done"}, 32'(cal_done), 0);
        check({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    task automatic do_reset(input logic [7:0] v);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        ad_data   = v;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic wait_cal_done(input string tag, input int exp_median);
        int guard;
        guard = 0;
        while (cal_done !== 1'b1 && guard < 6000) begin
            @(negedge sys_clk);
            guard++;
        end
        check({tag, "_cal_done"}, 32'(cal_done), 1);
        check({tag, "_median"}, 32'(median), 32'(exp_median));
    endtask

    // Sets a code while ad_clk is low, then reports the conversion of that sample.
    task automatic apply_raw(input logic [7:0] v, output int mv, output logic sgn, output int lat);
        int guard;
        guard = 0;
        while (ad_clk !== 1'b0 && guard < 16) begin
            @(negedge sys_clk);
            guard++;
        end
        ad_data = v;
        guard = 0;
        while (ad_clk !== 1'b1 && guard < 16) begin
            @(negedge sys_clk);
            guard++;
        end
        lat = 0;
        while (volt_valid !== 1'b1 && lat < 8) begin
            @(negedge sys_clk);
            lat++;
        end
        mv  = int'(volt_mv);
        sgn = volt_sign;
    endtask

    task automatic apply(input string tag, input logic [7:0] v, input int exp_mv, input logic exp_sign);
        int   mv;
        logic sgn;
        int   lat;
        apply_raw(v, mv, sgn, lat);
        check({tag, "_lat"}, 32'(lat), 2);
        check({tag, "_mv"}, 32'(mv), 32'(exp_mv));
        check({tag, "_sign"}, 32'(sgn), 32'(exp_sign));
    endtask

    initial begin
        int   lat;
        int   v0;
        int   guard;
        int   mv;
        logic sgn;
        int   prev_mv;
        int   max_mv;
        int   bad_lat;
        int   exp_mv;
        logic mono_ok;

        sys_rst_n = 1'b0;
        ad_data   = 8'd125;
`ifdef RECAL_EN
        recal = 1'b0;
`endif
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("rst0");

        // Calibration at code 125: no strobes, cal_done 52 cycles after the median lands.
        v0 = valid_cnt;
        sys_rst_n = 1'b1;
        guard = 0;
        while (median === 8'd0 && guard < 6000) begin
            @(negedge sys_clk);
            guard++;
        end
        check("cal125_median_early", 32'(median), 125);
        lat = 0;
        while (cal_done !== 1'b1 && lat < 100) begin
            @(negedge sys_clk);
            lat++;
        end
        check("cal125_done_latency", 32'(lat), 52);
        check("cal125_no_valid", 32'(valid_cnt - v0), 0);
        check("cal125_state_run", 32'(dbg_state), 3);

        apply("c255", 8'd255, 4999, 1'b0);
        apply("c0",   8'd0,   5000, 1'b1);
        apply("c126", 8'd126, 38,   1'b0);
        apply("c124", 8'd124, 40,   1'b1);
        apply("c125", 8'd125, 0,    1'b0);

        // Ramp 0..255, one code per ad_clk period.
        @(negedge sys_clk);
        v0      = valid_cnt;
        prev_mv = 5001;
        max_mv  = 0;
        bad_lat = 0;
        mono_ok = 1'b1;
        for (int code = 0; code < 256; code++) begin
            apply_raw(8'(code), mv, sgn, lat);
            if (code > 125) exp_mv = int'((longint'(code - 125) * 64'd315076) >> 13);
            else            exp_mv = int'((longint'(125 - code) * 64'd327680) >> 13);
            check("ramp_mv", 32'(mv), 32'(exp_mv));
            check("ramp_sign", 32'(sgn), (code < 125) ? 32'd1 : 32'd0);
            if (lat != 2) bad_lat++;
            if (code <= 125 && mv > prev_mv) mono_ok = 1'b0;
            if (code > 125 && mv < prev_mv) mono_ok = 1'b0;
            if (mv > max_mv) max_mv = mv;
            prev_mv = mv;
        end
        @(negedge sys_clk);
        check("ramp_monotonic", 32'(mono_ok), 1);
        check("ramp_max_le_5000", 32'(max_mv <= 5000), 1);
        check("ramp_max_value", 32'(max_mv), 5000);
        check("ramp_latency_errors", 32'(bad_lat), 0);
        check("ramp_valid_count", 32'(valid_cnt - v0), 256);

        // Clamp at the top: all-255 calibration gives median 254.
        do_reset(8'd255);
        wait_cal_done("cal255", 254);
        apply("m254_c255", 8'd255, 5000, 1'b0);
        apply("m254_c254", 8'd254, 0,    1'b0);
        apply("m254_c0",   8'd0,   4999, 1'b1);

        // Clamp at the bottom: all-0 calibration gives median 1.
        do_reset(8'd0);
        wait_cal_done("cal0", 1);
        apply("m1_c255", 8'd255, 4999, 1'b0);
        apply("m1_c0",   8'd0,   5000, 1'b1);

        // Reset for one cycle while the first division runs.
        do_reset(8'd77);
        guard = 0;
        while (dbg_state !== 2'd1 && guard < 6000) begin
            @(negedge sys_clk);
            guard++;
        end
        check("divp_reached", 32'(dbg_state), 1);
        check("divp_median", 32'(median), 77);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check_reset_outputs("rst_divp");
        ad_data   = 8'd100;
        sys_rst_n = 1'b1;
        wait_cal_done("cal100", 100);
        apply("m100_c0",   8'd0,   5000, 1'b1);
        apply("m100_c255", 8'd255, 4999, 1'b0);
        apply("m100_c101", 8'd101, 32,   1'b0);
        apply("m100_c99",  8'd99,  50,   1'b1);

`ifdef RECAL_EN
        @(negedge sys_clk);
        ad_data = 8'd130;
        recal   = 1'b1;
        @(negedge sys_clk);
        recal = 1'b0;
        check("recal_cal_done_low", 32'(cal_done), 0);
        check("recal_median_hold", 32'(median), 100);
        check("recal_state", 32'(dbg_state), 0);
        wait_cal_done("recal130", 130);
        apply("m130_c130", 8'd130, 0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
